// File: rtl/conv_fmap_pkg.sv
// Shared types and sizing helpers for the convolution feature-map buffer.
// Optional ReLU-on-write is selected by defining FMAP_RELU_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package conv_fmap_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      READY   = 2'd2
   } fmap_state_e;

   // Ceiling log2, never narrower than one bit.
   function automatic int logb2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if (v > 0) begin
            r = r + 1;
            v = v >> 1;
         end
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int fmap_depth(input int array_size, input int total_weight);
      return array_size * total_weight;
   endfunction

   function automatic int fmap_addr_width(input int array_size, input int total_weight);
      return logb2(fmap_depth(array_size, total_weight) * array_size);
   endfunction

   function automatic logic [`DATA_WIDTH-1:0] relu_word(input logic [`DATA_WIDTH-1:0] w);
      return w[`DATA_WIDTH-1] ? {`DATA_WIDTH{1'b0}} : w;
   endfunction

endpackage

// File: rtl/conv_fmap_ram.sv
// Row-wide feature-map storage: one full-row write port, one registered row read port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module conv_fmap_ram #(
   parameter int DEPTH      = 24,
   parameter int ROW_WIDTH  = 192,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [ROW_WIDTH-1:0]  i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [ROW_WIDTH-1:0]  o_rdata
);

   logic [ROW_WIDTH-1:0] r_mem [DEPTH];
   logic [ROW_WIDTH-1:0] r_rdata;

   // Storage array write; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read; holds the last row between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/conv_fmap_buffer.sv
// Collects conv-layer output rows into a full feature map and serves word reads.
// Define FMAP_RELU_EN to clamp negative words to zero as rows are stored.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module conv_fmap_buffer
   import conv_fmap_pkg::*;
#(
   parameter  int ARRAY_SIZE   = 6,
   parameter  int TOTAL_WEIGHT = 4,
   localparam int WEIGHT_WIDTH = logb2(TOTAL_WEIGHT),
   localparam int ARRAY_WIDTH  = logb2(ARRAY_SIZE),
   localparam int DEPTH        = fmap_depth(ARRAY_SIZE, TOTAL_WEIGHT),
   localparam int ADDR_WIDTH   = fmap_addr_width(ARRAY_SIZE, TOTAL_WEIGHT)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            valid,
   input  logic [WEIGHT_WIDTH-1:0]         feature_idx,
   input  logic [ARRAY_WIDTH-1:0]          feature_row,
   input  logic [ARRAY_SIZE*`DATA_WIDTH-1:0] feature_output,
   input  logic                            image_calc_fin,
   input  logic                            rd_en,
   input  logic [ADDR_WIDTH-1:0]           rd_addr,
   input  logic                            rd_release,
   output logic [`DATA_WIDTH-1:0]          rd_data,
   output logic                            rd_valid,
   output logic                            fmap_ready,
   output logic                            overflow,
   output logic                            incomplete
);

   localparam int DW       = `DATA_WIDTH;
   localparam int ROW_W    = ARRAY_SIZE * DW;
   localparam int RAM_AW   = logb2(DEPTH);
   localparam int ENTRY_W  = RAM_AW + 1;
   localparam int CNT_W    = logb2(DEPTH + 1);

   localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]      ONE_C     = CNT_W'(1);
   localparam logic [ENTRY_W-1:0]    DEPTH_E   = ENTRY_W'(DEPTH);
   localparam logic [ENTRY_W-1:0]    ASIZE_E   = ENTRY_W'(ARRAY_SIZE);
   localparam logic [ADDR_WIDTH-1:0] ASIZE_A   = ADDR_WIDTH'(ARRAY_SIZE);
   localparam logic [ADDR_WIDTH:0]   WORDS_C   = (ADDR_WIDTH+1)'(DEPTH * ARRAY_SIZE);

   fmap_state_e            r_state;
   fmap_state_e            w_next_state;
   logic [CNT_W-1:0]       r_row_cnt;
   logic [CNT_W-1:0]       w_row_cnt_nxt;
   logic                   r_valid_q;
   logic                   r_fmap_ready;
   logic                   r_overflow;
   logic                   r_incomplete;
   logic                   r_rd_valid;
   logic [ARRAY_WIDTH-1:0] r_rd_col;
   logic                   r_rd_oob;

   logic                   w_wr_edge;
   logic                   w_store;
   logic                   w_overflow_set;
   logic                   w_incomplete_set;
   logic [ENTRY_W-1:0]     w_wr_entry;
   logic                   w_ram_we;
   logic [ROW_W-1:0]       w_wr_row;
   logic                   w_rd_accept;
   logic                   w_rd_oob;
   logic [ARRAY_WIDTH-1:0] w_rd_col;
   logic [RAM_AW-1:0]      w_rd_row;
   logic [ROW_W-1:0]       w_ram_q;
   logic [DW-1:0]          w_word;

   assign w_wr_edge   = valid & ~r_valid_q;
   assign w_wr_entry  = ENTRY_W'(feature_idx) * ASIZE_E + ENTRY_W'(feature_row);
   assign w_ram_we    = w_store & (w_wr_entry < DEPTH_E);
   assign w_rd_accept = rd_en & (r_state == READY);
   assign w_rd_oob    = ({1'b0, rd_addr} >= WORDS_C);
   assign w_rd_row    = RAM_AW'(rd_addr / ASIZE_A);
   assign w_rd_col    = ARRAY_WIDTH'(rd_addr % ASIZE_A);

`ifdef FMAP_RELU_EN
   // Clamp each negative word of the incoming row to zero before storage.
   always_comb begin
      w_wr_row = '0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         w_wr_row[i*DW +: DW] = relu_word(feature_output[i*DW +: DW]);
      end
   end
`else
   assign w_wr_row = feature_output;
`endif

   // State, row counter and valid-edge history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_row_cnt <= '0;
         r_valid_q <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_row_cnt <= w_row_cnt_nxt;
         r_valid_q <= valid;
      end
   end

   // Next-state logic; a row write is counted before image_calc_fin is considered.
   always_comb begin
      w_next_state     = r_state;
      w_row_cnt_nxt    = r_row_cnt;
      w_store          = 1'b0;
      w_overflow_set   = 1'b0;
      w_incomplete_set = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_wr_edge) begin
               w_store       = 1'b1;
               w_row_cnt_nxt = ONE_C;
               w_next_state  = (ONE_C == DEPTH_C) ? READY : COLLECT;
            end else begin
               w_next_state  = IDLE;
            end
         end
         COLLECT: begin
            if (w_wr_edge) begin
               w_store       = 1'b1;
               w_row_cnt_nxt = r_row_cnt + ONE_C;
            end else begin
               w_store       = 1'b0;
            end
            if (w_row_cnt_nxt == DEPTH_C) begin
               w_next_state     = READY;
            end else if (image_calc_fin) begin
               w_incomplete_set = 1'b1;
               w_next_state     = READY;
            end else begin
               w_next_state     = COLLECT;
            end
         end
         READY: begin
            w_overflow_set = w_wr_edge;
            if (rd_release) begin
               w_next_state  = IDLE;
               w_row_cnt_nxt = '0;
            end else begin
               w_next_state  = READY;
            end
         end
         default: begin
            w_next_state  = IDLE;
            w_row_cnt_nxt = '0;
         end
      endcase
   end

   // Status flags; overflow and incomplete are sticky until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fmap_ready <= 1'b0;
         r_overflow   <= 1'b0;
         r_incomplete <= 1'b0;
      end else begin
         r_fmap_ready <= (w_next_state == READY);
         r_overflow   <= r_overflow | w_overflow_set;
         r_incomplete <= r_incomplete | w_incomplete_set;
      end
   end

   // Read qualifiers captured alongside the RAM row read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid <= 1'b0;
         r_rd_col   <= '0;
         r_rd_oob   <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_accept;
         if (w_rd_accept) begin
            r_rd_col <= w_rd_col;
            r_rd_oob <= w_rd_oob;
         end
      end
   end

   conv_fmap_ram #(
      .DEPTH      (DEPTH),
      .ROW_WIDTH  (ROW_W),
      .ADDR_WIDTH (RAM_AW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_ram_we),
      .i_waddr (RAM_AW'(w_wr_entry)),
      .i_wdata (w_wr_row),
      .i_re    (w_rd_accept & ~w_rd_oob),
      .i_raddr (w_rd_row),
      .o_rdata (w_ram_q)
   );

   // Column 0 occupies the most significant word of a row.
   always_comb begin
      w_word = '0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         w_word = w_word | ({DW{r_rd_col == ARRAY_WIDTH'(i)}} & w_ram_q[(ARRAY_SIZE-i)*DW-1 -: DW]);
      end
   end

   assign rd_data    = r_rd_oob ? '0 : w_word;
   assign rd_valid   = r_rd_valid;
   assign fmap_ready = r_fmap_ready;
   assign overflow   = r_overflow;
   assign incomplete = r_incomplete;

endmodule
